norm_shift_pipe: RTL

NORM_SHIFT_PIPE -- requirements
Module: norm_shift_pipe

---
 rtl/norm_shift_pipe.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/norm_shift_pipe.sv
// norm_shift_pipe -- pipelined barrel shifter with optional normalizer.
//
// Purpose:
//   Shifts WIDTH-bit operands left logical, right logical or right
//   arithmetic. The shift is log-decomposed: the shift-amount bits are
//   spread over PIPE register stages, with the low bits applied first.
//   Right shifts also report a sticky bit, which is the OR of every 1-bit
//   that was shifted out. A valid/ready handshake moves the beats through.
//   All stages advance together whenever in_ready is high.
//
// Optional feature (macro NORM_SHIFT_LZC_EN):
//   When the macro is defined, mode 2'b11 ignores in_amt. It left-shifts
//   the operand by its own leading-zero count and reports that count on
//   out_lzc. When the macro is undefined, mode 2'b11 is a plain left
//   logical shift by in_amt, out_lzc is tied to 0 and no LZC logic exists.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (clears stage valid flags)
//   in_valid   input beat valid
//   in_ready   block accepts a beat this cycle (out_ready || !out_valid)
//   in_data    operand, WIDTH bits
//   in_amt     unsigned shift amount, SHW bits
//   in_mode    00 left logical, 01 right logical, 10 right arith, 11 normalize
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   out_data   shifted result
//   out_sticky OR of the 1-bits discarded by a right shift
//   out_lzc    leading-zero count (normalize mode only, else 0)
module norm_shift_pipe #(
  parameter int WIDTH = 28,
  parameter int SHW   = 5,
  parameter int PIPE  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sticky,
  output logic [SHW-1:0]   out_lzc
);

  typedef struct packed {
    logic             sticky;
    logic [WIDTH-1:0] data;
  } step_t;

  // Stage i handles the amount bits [stage_lo(i), stage_lo(i+1)). Because
  // PIPE <= SHW, every stage gets at least one bit.
  function automatic int stage_lo(input int i);
    return (i * SHW) / PIPE;
  endfunction

  // Applies the power-of-two shifts selected by amt[hi-1:lo]. Each step
  // can shift by WIDTH or more. In that case every bit is discarded, so a
  // large total amount naturally gives zero (or sign fill). The sticky bit
  // then collects every operand bit.
  function automatic step_t shift_bits(
    input logic [WIDTH-1:0] d,
    input logic             st,
    input logic [SHW-1:0]   amt,
    input logic             left,
    input logic             arith,
    input int               lo,
    input int               hi
  );
    step_t                     r;
    logic signed [WIDTH-1:0]   sd;
    int                        s;
    r.data   = d;
    r.sticky = st;
    for (int b = 0; b < SHW; b++) begin
      if (b >= lo && b < hi && amt[b]) begin
        s = 1 << b;
        if (left) begin
          r.data = r.data << s;
        end else begin
          r.sticky = r.sticky | (|(r.data & ~({WIDTH{1'b1}} << s)));
          if (arith) begin
            // Keep the arithmetic shift in a signed-only expression so
            // that the sign fill is not lost to unsigned context.
            sd     = r.data;
            sd     = sd >>> s;
            r.data = sd;
          end else begin
            r.data = r.data >> s;
          end
        end
      end
    end
    return r;
  endfunction

`ifdef NORM_SHIFT_LZC_EN
  // Leading-zero count. A zero operand returns WIDTH. If WIDTH equals
  // 2**SHW, that value wraps in SHW bits. This does no harm to the shift,
  // because a zero operand shifts to zero whatever the amount.
  function automatic logic [SHW-1:0] lead_zeros(input logic [WIDTH-1:0] d);
    int   n;
    logic found;
    n     = 0;
    found = 1'b0;
    for (int b = WIDTH - 1; b >= 0; b--) begin
      if (!found) begin
        if (d[b]) found = 1'b1;
        else      n     = n + 1;
      end
    end
    return SHW'(n);
  endfunction
`endif

  logic                 adv;

  // Front-end decode: mode to shift direction and effective amount.
  logic                 front_left;
  logic                 front_arith;
  logic [SHW-1:0]       front_amt;

  // Per-stage combinational inputs and results.
  logic [WIDTH-1:0]     d_in     [PIPE];
  logic                 st_in    [PIPE];
  logic [SHW-1:0]       amt_in   [PIPE];
  logic                 left_in  [PIPE];
  logic                 arith_in [PIPE];
  logic                 vld_in   [PIPE];
  step_t                res      [PIPE];

  // Pipeline registers. Only the valid flags are reset. The data outputs
  // are gated by valid, so they still read 0 after reset.
  logic [WIDTH-1:0]     data_p   [PIPE];
  logic                 sticky_p [PIPE];
  logic [SHW-1:0]       amt_p    [PIPE];
  logic                 left_p   [PIPE];
  logic                 arith_p  [PIPE];
  logic                 vld_p    [PIPE];

`ifdef NORM_SHIFT_LZC_EN
  logic [SHW-1:0]       front_lzc;
  logic [SHW-1:0]       lzc_in   [PIPE];
  logic [SHW-1:0]       lzc_p    [PIPE];
`endif

  assign adv      = out_ready || !out_valid;
  assign in_ready = adv;

  always_comb begin
    front_left  = (in_mode == 2'b00) || (in_mode == 2'b11);
    front_arith = (in_mode == 2'b10);
    front_amt   = in_amt;
`ifdef NORM_SHIFT_LZC_EN
    front_lzc   = '0;
    if (in_mode == 2'b11) begin
      front_lzc = lead_zeros(in_data);
      front_amt = front_lzc;
    end
`endif
  end

  always_comb begin
    d_in[0]     = in_data;
    st_in[0]    = 1'b0;
    amt_in[0]   = front_amt;
    left_in[0]  = front_left;
    arith_in[0] = front_arith;
    vld_in[0]   = in_valid;
`ifdef NORM_SHIFT_LZC_EN
    lzc_in[0]   = front_lzc;
`endif
    for (int i = 1; i < PIPE; i++) begin
      d_in[i]     = data_p[i-1];
      st_in[i]    = sticky_p[i-1];
      amt_in[i]   = amt_p[i-1];
      left_in[i]  = left_p[i-1];
      arith_in[i] = arith_p[i-1];
      vld_in[i]   = vld_p[i-1];
`ifdef NORM_SHIFT_LZC_EN
      lzc_in[i]   = lzc_p[i-1];
`endif
    end
    for (int i = 0; i < PIPE; i++) begin
      res[i] = shift_bits(d_in[i], st_in[i], amt_in[i], left_in[i],
                          arith_in[i], stage_lo(i), stage_lo(i + 1));
    end
  end

  // Stage boundaries: stage i registers the result of its amount-bit slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE; i++) vld_p[i] <= 1'b0;
    end else if (adv) begin
      for (int i = 0; i < PIPE; i++) vld_p[i] <= vld_in[i];
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      for (int i = 0; i < PIPE; i++) begin
        data_p[i]   <= res[i].data;
        sticky_p[i] <= res[i].sticky;
        amt_p[i]    <= amt_in[i];
        left_p[i]   <= left_in[i];
        arith_p[i]  <= arith_in[i];
`ifdef NORM_SHIFT_LZC_EN
        lzc_p[i]    <= lzc_in[i];
`endif
      end
    end
  end

  assign out_valid  = vld_p[PIPE-1];
  assign out_data   = vld_p[PIPE-1] ? data_p[PIPE-1] : '0;
  assign out_sticky = vld_p[PIPE-1] & sticky_p[PIPE-1];
`ifdef NORM_SHIFT_LZC_EN
  assign out_lzc    = vld_p[PIPE-1] ? lzc_p[PIPE-1] : '0;
`else
  assign out_lzc    = '0;
`endif

endmodule
